// File: rtl/pc_fetch_unit_if.sv
// Control/ROM bus between the 8051 control unit, the program ROM and the
// program-counter / instruction-fetch stage.
interface pc_fetch_unit_if;
  logic        IRload;
  logic        PCload;
  logic        JMPload;
  logic [7:0]  rom_data;
  logic        acc_zero;
  logic        carry;
  logic [15:0] rom_addr;
  logic [15:0] pc;
  logic [7:0]  Opcode;
  logic [7:0]  operand;
  logic        stack_ovf;
  logic        stack_unf;

  // Control unit / ROM / datapath side
  modport master (
    output IRload, PCload, JMPload, rom_data, acc_zero, carry,
    input  rom_addr, pc, Opcode, operand, stack_ovf, stack_unf
  );

  // Fetch unit side
  modport slave (
    input  IRload, PCload, JMPload, rom_data, acc_zero, carry,
    output rom_addr, pc, Opcode, operand, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage for the 8051 control unit.
// Fetches opcode/operand bytes from a synchronous program ROM and applies
// JZ/JNZ/JNC/AJMP/ACALL/RET/RETI when the control unit raises JMPload.
// ACALL/RET use a small internal return-address stack (STACK_DEPTH must be a
// power of two and at least 2).
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 8
) (
  input logic            clock,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  typedef enum logic [2:0] {
    XFER_NONE,
    XFER_REL,
    XFER_ABS,
    XFER_CALL,
    XFER_RET
  } xfer_e;

  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  operand_q, operand_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        armed_q, armed_d;
  logic [15:0] stack_q [STACK_DEPTH];

  xfer_e       xfer;
  logic        relCond;
  logic        jumpFire;
  logic        pushEn;
  logic [IDX_W-1:0] pushIdx;
  logic [IDX_W-1:0] popIdx;
  logic [15:0] relTarget;
  logic [15:0] absTarget;

  assign jumpFire  = bus.JMPload && armed_q;
  assign pushIdx   = sp_q[IDX_W-1:0];
  assign popIdx    = IDX_W'(sp_q - SP_ONE);
  assign relTarget = pc_q + {{8{operand_q[7]}}, operand_q};
  assign absTarget = {pc_q[15:11], opcode_q[7:5], operand_q};

  // Decode the control-transfer class of the instruction held in IR
  always_comb begin
    xfer    = XFER_NONE;
    relCond = 1'b0;
    if (opcode_q == 8'h60) begin
      xfer    = XFER_REL;
      relCond = bus.acc_zero;
    end else if (opcode_q == 8'h70) begin
      xfer    = XFER_REL;
      relCond = !bus.acc_zero;
    end else if (opcode_q == 8'h50) begin
      xfer    = XFER_REL;
      relCond = !bus.carry;
    end else if (opcode_q[4:0] == 5'h01) begin
      xfer = XFER_ABS;
    end else if (opcode_q[4:0] == 5'h11) begin
      xfer = XFER_CALL;
    end else if (opcode_q == 8'h22 || opcode_q == 8'h32) begin
      xfer = XFER_RET;
    end
  end

  // Next-state logic: fetch loads and increment first, a taken jump then
  // overrides the pc (a transfer that does not redirect leaves the increment)
  always_comb begin
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    armed_d   = !bus.JMPload;
    pushEn    = 1'b0;

    if (bus.IRload) begin
      opcode_d = bus.rom_data;
    end
    if (bus.PCload && !bus.IRload) begin
      operand_d = bus.rom_data;
    end
    if (bus.PCload) begin
      pc_d = pc_q + 16'd1;
    end

    if (jumpFire) begin
      case (xfer)
        XFER_REL: begin
          if (relCond) begin
            pc_d = relTarget;
          end
        end
        XFER_ABS: begin
          pc_d = absTarget;
        end
        XFER_CALL: begin
          if (sp_q == SP_FULL) begin
            ovf_d = 1'b1;
          end else begin
            pushEn = 1'b1;
            sp_d   = sp_q + SP_ONE;
          end
          pc_d = absTarget;
        end
        XFER_RET: begin
          if (sp_q == '0) begin
            unf_d = 1'b1;
          end else begin
            sp_d = sp_q - SP_ONE;
            pc_d = stack_q[popIdx];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous reset; the stack empties via sp only
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      armed_q   <= armed_d;
    end
  end

  // Return-address storage: the pushed value is the address after the ACALL
  always_ff @(posedge clock) begin
    if (!reset && pushEn) begin
      stack_q[pushIdx] <= pc_q;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.pc        = pc_q;
  assign bus.Opcode    = opcode_q;
  assign bus.operand   = operand_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with a synchronous program ROM model.
module tb_pc_fetch_unit;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rom [0:65535];

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC   (16'h0000),
    .STACK_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Synchronous ROM: data for last cycle's address
  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic pcl, input logic jmp);
    bus.IRload  = ir;
    bus.PCload  = pcl;
    bus.JMPload = jmp;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // start, fetch1, then wait1/fetch2 for two-byte instructions
  task automatic fetchInstr(input bit twoByte);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    if (twoByte) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic execJump();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    bus.JMPload = 1'b0;
  endtask

  logic [15:0] retExp [9];

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    bus.rom_data = 8'h00;
    rom[16'h0000] = 8'h74; rom[16'h0001] = 8'h55;
    rom[16'h0002] = 8'h01; rom[16'h0003] = 8'h0E;
    rom[16'h000C] = 8'h60; rom[16'h000D] = 8'h02;
    rom[16'h000E] = 8'h60; rom[16'h000F] = 8'hFC;
    rom[16'h0010] = 8'h70; rom[16'h0011] = 8'h04;
    rom[16'h0016] = 8'h70; rom[16'h0017] = 8'h10;
    rom[16'h0018] = 8'h50; rom[16'h0019] = 8'h80;
    rom[16'h001A] = 8'h50; rom[16'h001B] = 8'h80;
    rom[16'hFF9C] = 8'h50; rom[16'hFF9D] = 8'h50;
    rom[16'hFFEE] = 8'h50; rom[16'hFFEF] = 8'h7F;
    rom[16'h006F] = 8'h50; rom[16'h0070] = 8'h8E;
    rom[16'h1232] = 8'h71; rom[16'h1233] = 8'h20;
    rom[16'h1320] = 8'h22;
    rom[16'h1234] = 8'h91; rom[16'h1235] = 8'h00;
    rom[16'h1236] = 8'h22;
    rom[16'h1237] = 8'h60; rom[16'h1238] = 8'h05;
    for (int j = 0; j < 8; j++) begin
      rom[16'h1400 + 16'(j * 16)]     = 8'h91;
      rom[16'h1401 + 16'(j * 16)]     = 8'((j + 1) * 16);
    end
    for (int j = 0; j < 7; j++) rom[16'h1402 + 16'(j * 16)] = 8'h22;
    rom[16'h1480] = 8'h22;
    retExp = '{16'h1462, 16'h1452, 16'h1442, 16'h1432, 16'h1422,
               16'h1412, 16'h1402, 16'h1236, 16'h1237};

    reset = 1'b1;
    bus.IRload = 1'b0; bus.PCload = 1'b0; bus.JMPload = 1'b0;
    bus.acc_zero = 1'b0; bus.carry = 1'b0;
    step();
    step();
    reset = 1'b0;
    checkOutput("reset_pc", bus.pc, 16'h0000);
    checkOutput("reset_rom_addr", bus.rom_addr, 16'h0000);
    checkOutput("reset_opcode", {8'h00, bus.Opcode}, 16'h0000);
    checkOutput("reset_operand", {8'h00, bus.operand}, 16'h0000);
    checkOutput("reset_ovf", {15'd0, bus.stack_ovf}, 16'h0000);
    checkOutput("reset_unf", {15'd0, bus.stack_unf}, 16'h0000);

    // MOV A,#55 fetch
    fetchInstr(1'b1);
    checkOutput("mov_opcode", {8'h00, bus.Opcode}, 16'h0074);
    checkOutput("mov_operand", {8'h00, bus.operand}, 16'h0055);
    checkOutput("mov_pc", bus.pc, 16'h0002);

    // AJMP 000E
    fetchInstr(1'b1);
    execJump();
    checkOutput("ajmp_pc", bus.pc, 16'h000E);

    // JZ -4 taken, exactly once over two JMPload cycles
    bus.acc_zero = 1'b1;
    fetchInstr(1'b1);
    checkOutput("jz_fetch_pc", bus.pc, 16'h0010);
    checkOutput("jz_opcode", {8'h00, bus.Opcode}, 16'h0060);
    checkOutput("jz_operand", {8'h00, bus.operand}, 16'h00FC);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jz_first_cycle", bus.pc, 16'h000C);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jz_once", bus.pc, 16'h000C);
    bus.JMPload = 1'b0;

    // JZ not taken (acc nonzero) twice
    bus.acc_zero = 1'b0;
    fetchInstr(1'b1);
    execJump();
    checkOutput("jz_nt_a", bus.pc, 16'h000E);
    fetchInstr(1'b1);
    execJump();
    checkOutput("jz_nt_b", bus.pc, 16'h0010);

    // JNZ taken then not taken
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnz_taken", bus.pc, 16'h0016);
    bus.acc_zero = 1'b1;
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnz_nt", bus.pc, 16'h0018);

    // JNC not taken, then backward wrap below zero
    bus.carry = 1'b1;
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnc_nt", bus.pc, 16'h001A);
    bus.carry = 1'b0;
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnc_wrap_back", bus.pc, 16'hFF9C);
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnc_fwd", bus.pc, 16'hFFEE);
    checkOutput("rom_addr_eq_pc", bus.rom_addr, 16'hFFEE);
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnc_wrap_fwd", bus.pc, 16'h006F);
    fetchInstr(1'b1);
    execJump();
    checkOutput("jnc_to_ffff", bus.pc, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pc_wrap_inc", bus.pc, 16'h0000);

    // Walk the pc up to 1232 by holding PCload
    bus.PCload = 1'b1;
    for (int i = 0; i < 16'h1232; i++) step();
    bus.PCload = 1'b0;
    checkOutput("pc_walk", bus.pc, 16'h1232);

    // ACALL page 3 then RET
    fetchInstr(1'b1);
    execJump();
    checkOutput("acall_pc", bus.pc, 16'h1320);
    fetchInstr(1'b0);
    checkOutput("ret_fetch_pc", bus.pc, 16'h1321);
    checkOutput("ret_opcode", {8'h00, bus.Opcode}, 16'h0022);
    execJump();
    checkOutput("ret_pc", bus.pc, 16'h1234);
    checkOutput("ret_no_unf", {15'd0, bus.stack_unf}, 16'h0000);

    // Nine nested ACALLs: the ninth overflows but still jumps
    for (int k = 0; k < 9; k++) begin
      fetchInstr(1'b1);
      execJump();
      checkOutput($sformatf("nest_call_%0d", k), bus.pc, 16'h1400 + 16'(k * 16));
      if (k == 7) checkOutput("ovf_before", {15'd0, bus.stack_ovf}, 16'h0000);
    end
    checkOutput("ovf_after", {15'd0, bus.stack_ovf}, 16'h0001);

    // Nine RETs: LIFO order, the ninth underflows and leaves pc alone
    for (int k = 0; k < 9; k++) begin
      fetchInstr(1'b0);
      execJump();
      checkOutput($sformatf("nest_ret_%0d", k), bus.pc, retExp[k]);
      if (k == 7) checkOutput("unf_before", {15'd0, bus.stack_unf}, 16'h0000);
    end
    checkOutput("unf_after", {15'd0, bus.stack_unf}, 16'h0001);

    // JZ taken while PCload is high in the same cycle: no extra increment
    bus.acc_zero = 1'b1;
    fetchInstr(1'b1);
    checkOutput("jzpc_fetch", bus.pc, 16'h1239);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("jz_with_pcload", bus.pc, 16'h123E);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jz_with_pcload_once", bus.pc, 16'h123E);

    // Re-arm, jump again, then reset in the middle of the JMPload run
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rearm_jump", bus.pc, 16'h1243);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("midreset_pc", bus.pc, 16'h0000);
    checkOutput("midreset_opcode", {8'h00, bus.Opcode}, 16'h0000);
    checkOutput("midreset_operand", {8'h00, bus.operand}, 16'h0000);
    checkOutput("midreset_ovf", {15'd0, bus.stack_ovf}, 16'h0000);
    checkOutput("midreset_unf", {15'd0, bus.stack_unf}, 16'h0000);

    // IRload alone loads IR without moving the pc
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("irload_only_opcode", {8'h00, bus.Opcode}, 16'h0074);
    checkOutput("irload_only_pc", bus.pc, 16'h0000);
    bus.IRload = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
